spi_mem_slave: RTL and testbench
================================

# spi_mem_slave

Byte-addressable SPI slave memory that sits directly downstream of `apb_spi_master`, on the far side of its `spi_clk`/`spi_sdo`/`spi_cs_n`/`spi_sdi` pins. It decodes a command/address/data frame and serves write, read, status and ID commands from an internal register array. It is the target device in SPI-path simulations and the golden slave for master regression. It oversamples the SPI pins with the system clock, so it has no SPI-clock domain.

## Interface
- `ADDR_WIDTH`, 8: memory address bits; array depth = 2^ADDR_WIDTH bytes; allowed range 1..16.
- `DEV_ID`, 8'hA5: byte returned by the ID command.
- `clk_i`  in  1  system clock; one clock; every flop is on its rising edge.
- `rst_n_i`  in  1  synchronous, active-low reset.
- `spi_clk_i`  in  1  SPI clock from the master, mode 0 (CPOL=0, CPHA=0).
- `spi_cs_n_i`  in  1  active-low chip select.
- `spi_sdi_i`  in  1  serial data from the master (master `spi_sdo`).
- `spi_sdo_o`  out  1  serial data to the master (master `spi_sdi`).
- `bk_addr_i`  in  ADDR_WIDTH  backdoor read address, for bench visibility.
- `bk_rdata_o`  out  8  combinational `mem[bk_addr_i]`.
- `busy_o`  out  1  high while a frame is active (state != IDLE).

## Operation
- **Input sync:** 2-flop synchronizers on `spi_clk_i`, `spi_cs_n_i` and `spi_sdi_i`, plus one extra delay flop on the clock for edge detection.
  - `rise` = sync_clk & ~prev_clk.
  - `fall` = ~sync_clk & prev_clk.
- **Frame:** MSB first. Command byte, then 16-bit address (the low ADDR_WIDTH bits are used, the rest ignored), then data bytes. Bits are sampled on `rise`.
- **States:** IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE -> CMD when sync cs_n goes low.
  - CMD, after 8 bits:
    - 0x02 -> ADDR (write)
    - 0x03 -> ADDR (read)
    - 0x05 -> RDATA, loading the status byte
    - 0x9F -> RDATA, loading DEV_ID
    - anything else -> IGNORE
  - ADDR, after 16 bits: write -> WDATA; read -> RDATA, loading `mem[addr]`.
  - Any state -> IDLE when sync cs_n is high. This has priority over any same-cycle edge.
- **Counters:** 3-bit bit counter, cleared on frame start and on every byte boundary. A separate 4-bit counter covers the address phase.
- **WDATA:**
  - On the 8th `rise` of a byte: `mem[addr] <= byte`, `addr <= addr+1` mod 2^ADDR_WIDTH (wraps), `wr_count <= wr_count+1` mod 256.
  - A partial byte at CS deassert is discarded.
- **RDATA:**
  - The shift register is loaded at state entry. `spi_sdo_o` is updated on each `fall` with the next bit, MSB first.
  - After the 8th `rise`, the next byte is loaded: `mem[addr+1]` for read (address auto-increments and wraps), status re-sampled for 0x05, DEV_ID for 0x9F.
- **Status byte:** `wr_count`, the number of bytes written since reset, mod 256.
- **`spi_sdo_o`:** driven 0 in IDLE, CMD, ADDR, WDATA and IGNORE.
- **Reset** (synchronous, any time, including mid-frame):
  - state IDLE; counters, `addr`, `wr_count` and shift registers 0; all memory bytes 8'h00.
  - `spi_sdo_o` 0, `busy_o` 0, `bk_rdata_o` 8'h00 for any address.
  - Synchronizer flops reset to the idle pin levels: clk 0, cs_n 1, sdi 0.

## Timing
- Pin-to-internal latency is 2 `clk_i` cycles; edge detect adds 1.
- SPI clock high and low phases must each be ≥ 4 `clk_i` cycles. Faster SPI clocks are unsupported.
- **First read bit:** the first data MSB appears on `spi_sdo_o` at the `fall` that follows the last address (or command) bit. That is ≤ 3 `clk_i` after the `spi_clk_i` falling edge, well before the master samples on the next rising edge.
- The memory write occurs 1 `clk_i` after the detected 8th `rise`.
- `busy_o` rises 3 cycles after `spi_cs_n_i` falls and drops 3 cycles after it rises.
- Back-to-back frames need ≥ 4 `clk_i` of cs_n high.

## Test plan
- **Write/read:** frame 02 00 10 DE AD BE EF -> `bk_rdata_o` at 0x10..0x13 = DE, AD, BE, EF. Then frame 03 00 10 + 4 dummy bytes -> master receives DE AD BE EF.
- **Wrap:** write 02 00 FF 11 22 with ADDR_WIDTH=8 -> `mem[0xFF]` = 11, `mem[0x00]` = 22.
- **Status and ID:** after the 6 bytes written above, frame 05 + 1 byte -> 0x06. Frame 9F + 2 bytes -> A5 A5.
- **Abort and partial byte:** 02 00 20 AB, then 4 bits of 0xC, then cs_n high -> `mem[0x20]` = AB, `mem[0x21]` = 00, status = 0x07; `busy_o` low 3 cycles after cs_n rises.
- **Unknown command:** frame 7E + 2 bytes -> `spi_sdo_o` stays 0, memory unchanged.
- **Reset mid-read:** assert `rst_n_i` during frame 03 00 10 -> next `clk_i`: `spi_sdo_o` = 0, `busy_o` = 0, all `bk_rdata_o` = 00, status = 0x00.

Source files
------------

// File: rtl/spi_mem_slave.sv
// rtl/spi_mem_slave.sv - SPI mode-0 slave memory oversampled by the system clock
//
// Serves write (0x02), read (0x03), status (0x05) and ID (0x9F) frames of the
// form command byte, 16-bit address, data bytes, all MSB first.
//
// Ports:
//   clk_i       system clock, all flops on its rising edge
//   rst_n_i     synchronous active-low reset
//   spi_clk_i   SPI clock from the master (CPOL=0, CPHA=0)
//   spi_cs_n_i  active-low chip select
//   spi_sdi_i   serial data from the master
//   spi_sdo_o   serial data to the master, 0 outside read-data phase
//   bk_addr_i   backdoor read address
//   bk_rdata_o  combinational mem[bk_addr_i]
//   busy_o      high while a frame is being decoded
module spi_mem_slave #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] DEV_ID     = 8'hA5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_sdi_i,
    output logic                  spi_sdo_o,
    input  logic [ADDR_WIDTH-1:0] bk_addr_i,
    output logic [7:0]            bk_rdata_o,
    output logic                  busy_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_STATUS = 2'd2;
    localparam logic [1:0] OP_ID     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic clk_s1, clk_s2, clk_prev;
    logic cs_s1, cs_s2;
    logic sdi_s1, sdi_s2;

    logic [2:0]            bit_cnt;
    logic [3:0]            addr_cnt;
    logic [6:0]            shift_in;
    logic [7:0]            shift_out;
    logic                  sdo_q;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wr_count;
    logic [7:0]            mem [DEPTH];

    logic                  rise, fall, byte_done, addr_done;
    logic [7:0]            byte_in;
    logic [ADDR_WIDTH-1:0] addr_shift, addr_nxt;

    // Synchronizers reset to the idle pin levels so a reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            clk_prev <= 1'b0;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            sdi_s1   <= 1'b0;
            sdi_s2   <= 1'b0;
        end else begin
            clk_s1   <= spi_clk_i;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            cs_s1    <= spi_cs_n_i;
            cs_s2    <= cs_s1;
            sdi_s1   <= spi_sdi_i;
            sdi_s2   <= sdi_s1;
        end
    end

    always_comb begin
        rise      = clk_s2 & ~clk_prev;
        fall      = ~clk_s2 & clk_prev;
        byte_in   = {shift_in, sdi_s2};
        byte_done = rise && (bit_cnt == 3'd7);
        addr_done = rise && (addr_cnt == 4'hF);
        // Shifting all 16 address bits through an ADDR_WIDTH register keeps
        // only the low bits, which is exactly the address we decode.
        addr_shift = ADDR_WIDTH'({addr, sdi_s2});
        addr_nxt   = addr + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cs_s2) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        case (byte_in)
                            8'h02, 8'h03: state_nxt = ST_ADDR;
                            8'h05, 8'h9F: state_nxt = ST_RDATA;
                            default:      state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (addr_done) begin
                        state_nxt = (op == OP_READ) ? ST_RDATA : ST_WDATA;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bit_cnt   <= 3'd0;
            addr_cnt  <= 4'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'd0;
            sdo_q     <= 1'b0;
            op        <= OP_WRITE;
            addr      <= '0;
            wr_count  <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[ADDR_WIDTH'(i)] <= 8'h00;
            end
        end else if (cs_s2 || state == ST_IDLE) begin
            // Frame boundary: any partial byte is dropped here.
            bit_cnt   <= 3'd0;
            addr_cnt  <= 4'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'd0;
            sdo_q     <= 1'b0;
        end else begin
            case (state)
                ST_CMD: begin
                    if (rise) begin
                        shift_in <= byte_in[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                    if (byte_done) begin
                        case (byte_in)
                            8'h02: op <= OP_WRITE;
                            8'h03: op <= OP_READ;
                            8'h05: begin
                                op        <= OP_STATUS;
                                shift_out <= wr_count;
                            end
                            8'h9F: begin
                                op        <= OP_ID;
                                shift_out <= DEV_ID;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        addr     <= addr_shift;
                        addr_cnt <= addr_cnt + 4'd1;
                    end
                    if (addr_done && op == OP_READ) begin
                        shift_out <= mem[addr_shift];
                    end
                end
                ST_WDATA: begin
                    if (rise) begin
                        shift_in <= byte_in[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                    if (byte_done) begin
                        mem[addr] <= byte_in;
                        addr      <= addr_nxt;
                        wr_count  <= wr_count + 8'd1;
                    end
                end
                ST_RDATA: begin
                    // Present the next bit on the falling edge so it is stable
                    // for the master's rising-edge sample.
                    if (fall) begin
                        sdo_q     <= shift_out[7];
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                    if (rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (byte_done) begin
                        case (op)
                            OP_READ: begin
                                addr      <= addr_nxt;
                                shift_out <= mem[addr_nxt];
                            end
                            OP_STATUS: shift_out <= wr_count;
                            default:   shift_out <= DEV_ID;
                        endcase
                    end
                end
                ST_IGNORE: begin
                    if (rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_sdo_o  = (state == ST_RDATA) & sdo_q;
    assign busy_o     = (state != ST_IDLE);
    assign bk_rdata_o = mem[bk_addr_i];

endmodule

// File: tb/tb_spi_mem_slave.sv
// tb/tb_spi_mem_slave.sv - directed bench for spi_mem_slave
module tb_spi_mem_slave;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_sdi = 1'b0;
    logic       spi_sdo;
    logic [7:0] bk_addr = 8'h00;
    logic [7:0] bk_rdata;
    logic       busy;

    int tests = 0;
    int fails = 0;

    spi_mem_slave #(
        .ADDR_WIDTH(8),
        .DEV_ID    (8'hA5)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .spi_clk_i (spi_clk),
        .spi_cs_n_i(spi_cs_n),
        .spi_sdi_i (spi_sdi),
        .spi_sdo_o (spi_sdo),
        .bk_addr_i (bk_addr),
        .bk_rdata_o(bk_rdata),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_sdi = b;
        wait_clk(HALF);
        spi_clk = 1'b1;
        r = spi_sdo;
        wait_clk(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic spi_start();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_end();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        spi_sdi  = 1'b0;
        wait_clk(8);
    endtask

    task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bk_addr = a;
        #1;
        check(tag, bk_rdata, exp);
    endtask

    initial begin
        logic [7:0] rx;
        logic       r;
        int         nz;

        // Reset state
        wait_clk(3);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_sdo", {7'd0, spi_sdo}, 8'h00);
        peek("rst_mem10", 8'h10, 8'h00);
        rst_n = 1'b1;
        wait_clk(2);

        // Write DE AD BE EF at 0x10, with busy latency on cs_n fall
        spi_cs_n = 1'b0;
        wait_clk(2);
        check("busy_rise_2cyc", {7'd0, busy}, 8'h00);
        wait_clk(1);
        check("busy_rise_3cyc", {7'd0, busy}, 8'h01);
        wait_clk(HALF - 3);
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'hDE, rx);
        spi_byte(8'hAD, rx);
        spi_byte(8'hBE, rx);
        spi_byte(8'hEF, rx);
        spi_end();
        peek("wr_mem10", 8'h10, 8'hDE);
        peek("wr_mem11", 8'h11, 8'hAD);
        peek("wr_mem12", 8'h12, 8'hBE);
        peek("wr_mem13", 8'h13, 8'hEF);

        // Read back through SPI
        spi_start();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        check("rd_byte0", rx, 8'hDE);
        spi_byte(8'h00, rx);
        check("rd_byte1", rx, 8'hAD);
        spi_byte(8'h00, rx);
        check("rd_byte2", rx, 8'hBE);
        spi_byte(8'h00, rx);
        check("rd_byte3", rx, 8'hEF);
        spi_end();

        // Address wrap
        spi_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_end();
        peek("wrap_memFF", 8'hFF, 8'h11);
        peek("wrap_mem00", 8'h00, 8'h22);

        // Status and ID
        spi_start();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        check("status_6", rx, 8'h06);
        spi_end();
        spi_start();
        spi_byte(8'h9F, rx);
        spi_byte(8'h00, rx);
        check("id_byte0", rx, 8'hA5);
        spi_byte(8'h00, rx);
        check("id_byte1", rx, 8'hA5);
        spi_end();

        // Abort with a partial byte
        spi_start();
        spi_byte(8'h02, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h20, rx);
        spi_byte(8'hAB, rx);
        spi_bit(1'b1, r);
        spi_bit(1'b1, r);
        spi_bit(1'b0, r);
        spi_bit(1'b0, r);
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        spi_sdi  = 1'b0;
        wait_clk(2);
        check("busy_fall_2cyc", {7'd0, busy}, 8'h01);
        wait_clk(1);
        check("busy_fall_3cyc", {7'd0, busy}, 8'h00);
        wait_clk(5);
        peek("abort_mem20", 8'h20, 8'hAB);
        peek("abort_mem21", 8'h21, 8'h00);
        spi_start();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        check("status_7", rx, 8'h07);
        spi_end();

        // Unknown command
        spi_start();
        spi_byte(8'h7E, rx);
        check("unk_cmd_sdo", rx, 8'h00);
        spi_byte(8'hFF, rx);
        check("unk_byte0", rx, 8'h00);
        spi_byte(8'hFF, rx);
        check("unk_byte1", rx, 8'h00);
        spi_end();
        peek("unk_mem10", 8'h10, 8'hDE);
        peek("unk_mem00", 8'h00, 8'h22);
        peek("unk_memFF", 8'hFF, 8'h11);

        // Reset in the middle of a read
        spi_start();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h10, rx);
        spi_bit(1'b0, r);
        check("mid_rd_bit7", {7'd0, r}, 8'h01);
        wait_clk(4);
        check("mid_rd_bit6", {7'd0, spi_sdo}, 8'h01);
        rst_n = 1'b0;
        wait_clk(1);
        check("mid_rst_sdo", {7'd0, spi_sdo}, 8'h00);
        check("mid_rst_busy", {7'd0, busy}, 8'h00);
        nz = 0;
        for (int a = 0; a < 256; a++) begin
            bk_addr = 8'(a);
            #1;
            if (bk_rdata !== 8'h00) nz++;
        end
        check("mid_rst_mem_nonzero", 8'(nz), 8'h00);
        spi_cs_n = 1'b1;
        spi_sdi  = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        spi_start();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        check("status_after_rst", rx, 8'h00);
        spi_end();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
